// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
//   W, D         : data width / register pointer width
//   R0_ADDR      : constant-zero register (writes suppressed)
//   CMP_ADDR     : branch comparison register (writes flagged)
//   TMO_CYC_DEF  : default load watchdog limit
//   wb_state_e   : stage state (IDLE, LOAD_WAIT)
//   wb_wr_t      : register-file write payload (dest + data)
package wb_pkg;

    localparam int unsigned W           = 8;
    localparam int unsigned D           = 3;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned TMO_CYC_DEF = 15;

    localparam logic [D-1:0] R0_ADDR  = 3'd0;
    localparam logic [D-1:0] CMP_ADDR = 3'd7;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [D-1:0] dest;
        logic [W-1:0] data;
    } wb_wr_t;

endpackage

// File: rtl/wb_stage_if.sv
// Execute -> write-back retire handshake.
//   master (execute): in_valid, in_wr, in_is_load, in_dest, in_alu_data out; in_ready in
//   slave  (wb_stage): the reverse
interface wb_stage_if;
    import wb_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic         in_wr;
    logic         in_is_load;
    logic [D-1:0] in_dest;
    logic [W-1:0] in_alu_data;

    modport master (
        output in_valid, in_wr, in_is_load, in_dest, in_alu_data,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_wr, in_is_load, in_dest, in_alu_data,
        output in_ready
    );

endinterface

// File: rtl/wb_tmo_ctr.sv
// Load watchdog: counts LOAD_WAIT cycles without returned data.
//   clk, reset_n : clock, synchronous active-low reset
//   clr          : restart count at 0 (held while the stage is idle)
//   en           : advance count by one
//   expired      : count has reached TMO_CYC
module wb_tmo_ctr
    import wb_pkg::*;
#(
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] r_count;

    assign expired = (r_count == CNT_W'(TMO_CYC));

    // Saturates at the limit so a late enable cannot wrap past expiry.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && !expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: sole driver of the register-file write port.
// ALU results commit one cycle after acceptance; loads wait in LOAD_WAIT
// for data memory, bounded by a watchdog. Writes to r0 are suppressed and
// flagged, writes to r7 pulse cmp_updated.
//   clk, reset_n          : clock, synchronous active-low reset
//   ex                    : retire handshake from execute (slave side)
//   mem_valid, mem_rdata  : data memory read return
//   rf_write_en/w_addr/data_in : register-file write port (registered)
//   cmp_updated           : pulses with a write to r7
//   r0_wr_flag, tmo_err   : sticky status flags
//   wb_count              : committed write count, wraps
//   byp_addr_a/b, byp_hit_a/b, byp_data : write-to-read bypass
// Optional feature macro: WB_BYPASS_EN enables the bypass compare;
// without it the bypass outputs are tied to 0.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    wb_stage_if.slave        ex,
    input  logic             mem_valid,
    input  logic [W-1:0]     mem_rdata,
    output logic             rf_write_en,
    output logic [D-1:0]     rf_w_addr,
    output logic [W-1:0]     rf_data_in,
    output logic             cmp_updated,
    output logic             r0_wr_flag,
    output logic             tmo_err,
    output logic [CNT_W-1:0] wb_count,
    input  logic [D-1:0]     byp_addr_a,
    input  logic [D-1:0]     byp_addr_b,
    output logic             byp_hit_a,
    output logic             byp_hit_b,
    output logic [W-1:0]     byp_data
);

    wb_state_e        r_state;
    logic             r_in_ready;
    logic [D-1:0]     r_ld_dest;
    logic             r_wr_en;
    wb_wr_t           r_wr;
    logic             r_cmp;
    logic             r_r0;
    logic             r_tmo;
    logic [CNT_W-1:0] r_cnt;

    logic   w_accept;
    logic   w_commit;
    wb_wr_t w_cm;
    logic   w_expired;
    logic   w_tmo_clr;
    logic   w_tmo_en;

    assign ex.in_ready = r_in_ready;
    assign w_accept    = ex.in_valid & r_in_ready;
    assign w_tmo_clr   = (r_state == IDLE);
    assign w_tmo_en    = (r_state == LOAD_WAIT) & ~mem_valid;

    wb_tmo_ctr #(.TMO_CYC(TMO_CYC)) u_tmo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_tmo_clr),
        .en      (w_tmo_en),
        .expired (w_expired)
    );

    // Select the write candidate for this cycle: ALU retire or load return.
    always_comb begin
        w_commit  = 1'b0;
        w_cm.dest = r_ld_dest;
        w_cm.data = mem_rdata;
        if (r_state == IDLE) begin
            w_commit  = w_accept & ex.in_wr & ~ex.in_is_load;
            w_cm.dest = ex.in_dest;
            w_cm.data = ex.in_alu_data;
        end else begin
            w_commit  = mem_valid;
        end
    end

    // State, handshake and write-port registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_ld_dest  <= '0;
            r_wr_en    <= 1'b0;
            r_wr       <= '0;
            r_cmp      <= 1'b0;
            r_r0       <= 1'b0;
            r_tmo      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_wr_en <= 1'b0;
            r_cmp   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_accept && ex.in_wr && ex.in_is_load) begin
                        r_state    <= LOAD_WAIT;
                        r_in_ready <= 1'b0;
                        r_ld_dest  <= ex.in_dest;
                    end
                end
                LOAD_WAIT: begin
                    // Returned data takes priority over a same-cycle expiry.
                    if (mem_valid) begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                    end else if (w_expired) begin
                        r_state    <= IDLE;
                        r_in_ready <= 1'b1;
                        r_tmo      <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase

            // r0 writes leave the write port (including held addr/data) untouched.
            if (w_commit) begin
                if (w_cm.dest == R0_ADDR) begin
                    r_r0 <= 1'b1;
                end else begin
                    r_wr_en <= 1'b1;
                    r_wr    <= w_cm;
                    r_cmp   <= (w_cm.dest == CMP_ADDR);
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign rf_write_en = r_wr_en;
    assign rf_w_addr   = r_wr.dest;
    assign rf_data_in  = r_wr.data;
    assign cmp_updated = r_cmp;
    assign r0_wr_flag  = r_r0;
    assign tmo_err     = r_tmo;
    assign wb_count    = r_cnt;

`ifdef WB_BYPASS_EN
    // Forward the in-flight write to same-cycle RF readers.
    assign byp_hit_a = r_wr_en & (r_wr.dest == byp_addr_a) & (r_wr.dest != R0_ADDR);
    assign byp_hit_b = r_wr_en & (r_wr.dest == byp_addr_b) & (r_wr.dest != R0_ADDR);
    assign byp_data  = r_wr.data;
`else
    logic w_unused_byp;
    assign w_unused_byp = ^{byp_addr_a, byp_addr_b};
    assign byp_hit_a    = 1'b0;
    assign byp_hit_b    = 1'b0;
    assign byp_data     = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model.
module tb_wb_stage;
    import wb_pkg::*;

    localparam int unsigned TMO = 15;

    logic         clk;
    logic         reset_n;
    logic         mem_valid;
    logic [W-1:0] mem_rdata;
    logic         rf_write_en;
    logic [D-1:0] rf_w_addr;
    logic [W-1:0] rf_data_in;
    logic         cmp_updated;
    logic         r0_wr_flag;
    logic         tmo_err;
    logic [7:0]   wb_count;
    logic [D-1:0] byp_addr_a;
    logic [D-1:0] byp_addr_b;
    logic         byp_hit_a;
    logic         byp_hit_b;
    logic [W-1:0] byp_data;

    wb_stage_if ex_if ();

    wb_stage #(.TMO_CYC(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ex          (ex_if),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .rf_write_en (rf_write_en),
        .rf_w_addr   (rf_w_addr),
        .rf_data_in  (rf_data_in),
        .cmp_updated (cmp_updated),
        .r0_wr_flag  (r0_wr_flag),
        .tmo_err     (tmo_err),
        .wb_count    (wb_count),
        .byp_addr_a  (byp_addr_a),
        .byp_addr_b  (byp_addr_b),
        .byp_hit_a   (byp_hit_a),
        .byp_hit_b   (byp_hit_b),
        .byp_data    (byp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model of the stage.
    bit       m_busy;
    int       m_dest_ld;
    int       m_waited;
    bit       m_wr;
    int       m_addr;
    int       m_data;
    bit       m_cmp;
    bit       m_r0;
    bit       m_tmo;
    int       m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic void m_write(input int d, input int v);
        if (d == 0) begin
            m_r0 = 1'b1;
        end else begin
            m_wr   = 1'b1;
            m_addr = d;
            m_data = v;
            m_cmp  = (d == 7);
            m_cnt  = (m_cnt + 1) % 256;
        end
    endfunction

    function automatic void m_clock();
        m_wr  = 1'b0;
        m_cmp = 1'b0;
        if (!reset_n) begin
            m_busy = 1'b0; m_waited = 0; m_addr = 0; m_data = 0;
            m_r0 = 1'b0; m_tmo = 1'b0; m_cnt = 0;
        end else if (!m_busy) begin
            if (ex_if.in_valid && ex_if.in_wr) begin
                if (ex_if.in_is_load) begin
                    m_busy = 1'b1; m_dest_ld = int'(ex_if.in_dest); m_waited = 0;
                end else begin
                    m_write(int'(ex_if.in_dest), int'(ex_if.in_alu_data));
                end
            end
        end else begin
            if (mem_valid) begin
                m_write(m_dest_ld, int'(mem_rdata));
                m_busy = 1'b0;
            end else if (m_waited == int'(TMO)) begin
                m_tmo  = 1'b1;
                m_busy = 1'b0;
            end else begin
                m_waited++;
            end
        end
    endfunction

    // Advance one clock, update the model, then compare every output.
    task automatic step();
        bit exp_ha, exp_hb;
        int exp_bd;
        @(posedge clk);
        m_clock();
        #1;
`ifdef WB_BYPASS_EN
        exp_ha = m_wr && (m_addr == int'(byp_addr_a)) && (m_addr != 0);
        exp_hb = m_wr && (m_addr == int'(byp_addr_b)) && (m_addr != 0);
        exp_bd = m_data;
`else
        exp_ha = 1'b0;
        exp_hb = 1'b0;
        exp_bd = 0;
`endif
        chk("in_ready",    32'(ex_if.in_ready), 32'(!m_busy));
        chk("rf_write_en", 32'(rf_write_en),    32'(m_wr));
        chk("rf_w_addr",   32'(rf_w_addr),      32'(m_addr));
        chk("rf_data_in",  32'(rf_data_in),     32'(m_data));
        chk("cmp_updated", 32'(cmp_updated),    32'(m_cmp));
        chk("r0_wr_flag",  32'(r0_wr_flag),     32'(m_r0));
        chk("tmo_err",     32'(tmo_err),        32'(m_tmo));
        chk("wb_count",    32'(wb_count),       32'(m_cnt));
        chk("byp_hit_a",   32'(byp_hit_a),      32'(exp_ha));
        chk("byp_hit_b",   32'(byp_hit_b),      32'(exp_hb));
        chk("byp_data",    32'(byp_data),       32'(exp_bd));
    endtask

    task automatic drive(input bit v, input bit wr, input bit ld, input int dest,
                         input int data, input bit mv, input int mrd);
        ex_if.in_valid    = v;
        ex_if.in_wr       = wr;
        ex_if.in_is_load  = ld;
        ex_if.in_dest     = D'(dest);
        ex_if.in_alu_data = W'(data);
        mem_valid         = mv;
        mem_rdata         = W'(mrd);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        byp_addr_a = '0;
        byp_addr_b = '0;
        idle();
        step();
        step();
        chk("rst_ready", 32'(ex_if.in_ready), 32'd1);
        chk("rst_wr",    32'(rf_write_en),    32'd0);
        chk("rst_cnt",   32'(wb_count),       32'd0);
        reset_n = 1'b1;
        step();

        // ALU write, one-cycle latency
        drive(1'b1, 1'b1, 1'b0, 3, 8'h5A, 1'b0, 0);
        step();
        chk("t1_wr",   32'(rf_write_en), 32'd1);
        chk("t1_addr", 32'(rf_w_addr),   32'd3);
        chk("t1_data", 32'(rf_data_in),  32'h5A);
        chk("t1_cnt",  32'(wb_count),    32'd1);
        idle();

        // Load returning after four wait cycles
        drive(1'b1, 1'b1, 1'b1, 2, 0, 1'b0, 0);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_ready_low", 32'(ex_if.in_ready), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 8'hC3);
        step();
        chk("t2_wr",    32'(rf_write_en),    32'd1);
        chk("t2_addr",  32'(rf_w_addr),      32'd2);
        chk("t2_data",  32'(rf_data_in),     32'hC3);
        chk("t2_ready", 32'(ex_if.in_ready), 32'd1);
        idle();

        // r0 suppression and r7 compare update
        drive(1'b1, 1'b1, 1'b0, 0, 8'h11, 1'b0, 0);
        step();
        chk("t3_r0_nowr", 32'(rf_write_en), 32'd0);
        chk("t3_r0_flag", 32'(r0_wr_flag),  32'd1);
        drive(1'b1, 1'b1, 1'b0, 7, 8'h01, 1'b0, 0);
        step();
        chk("t3_r7_wr",  32'(rf_write_en), 32'd1);
        chk("t3_r7_cmp", 32'(cmp_updated), 32'd1);
        idle();
        step();

        // Watchdog expiry with no data
        drive(1'b1, 1'b1, 1'b1, 5, 0, 1'b0, 0);
        step();
        idle();
        for (int i = 0; i < int'(TMO); i++) step();
        chk("t4_tmo_pre", 32'(tmo_err), 32'd0);
        step();
        chk("t4_tmo",   32'(tmo_err),        32'd1);
        chk("t4_nowr",  32'(rf_write_en),    32'd0);
        chk("t4_ready", 32'(ex_if.in_ready), 32'd1);
        // Data arriving on the expiry cycle wins
        drive(1'b1, 1'b1, 1'b1, 6, 0, 1'b0, 0);
        step();
        idle();
        for (int i = 0; i < int'(TMO); i++) step();
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 8'h9E);
        step();
        chk("t4b_wr",   32'(rf_write_en), 32'd1);
        chk("t4b_data", 32'(rf_data_in),  32'h9E);
        chk("t4b_tmo",  32'(tmo_err),     32'd1);
        idle();

        // Bypass on an in-flight write
        byp_addr_a = 3'd4;
        byp_addr_b = 3'd0;
        drive(1'b1, 1'b1, 1'b0, 4, 8'h77, 1'b0, 0);
        step();
`ifdef WB_BYPASS_EN
        chk("t6_hit_a", 32'(byp_hit_a), 32'd1);
        chk("t6_data",  32'(byp_data),  32'h77);
`else
        chk("t6_hit_a", 32'(byp_hit_a), 32'd0);
        chk("t6_data",  32'(byp_data),  32'd0);
`endif
        chk("t6_hit_b", 32'(byp_hit_b), 32'd0);
        idle();

        // Reset during LOAD_WAIT aborts the load
        drive(1'b1, 1'b1, 1'b1, 3, 0, 1'b0, 0);
        step();
        idle();
        step();
        step();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 8'hAB);
        step();
        reset_n = 1'b1;
        step();
        chk("t5_nowr",  32'(rf_write_en),    32'd0);
        chk("t5_ready", 32'(ex_if.in_ready), 32'd1);
        chk("t5_cnt",   32'(wb_count),       32'd0);
        chk("t5_tmo",   32'(tmo_err),        32'd0);
        chk("t5_r0",    32'(r0_wr_flag),     32'd0);
        idle();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 2) == 0, ($urandom % 4) != 0, ($urandom % 10) < 3,
                  int'($urandom % 8), int'($urandom % 256),
                  ($urandom % 100) < 15, int'($urandom % 256));
            byp_addr_a = D'($urandom % 8);
            byp_addr_b = D'($urandom % 8);
            reset_n    = ($urandom % 100) != 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
